// File: rtl/front_panel.sv
// -----------------------------------------------------------------------------
// front_panel
//
// Purpose:
//   Turns five raw, bouncing front-panel push switches into clean, fixed-width
//   command pulses for the sequencer. Each switch is synchronized, debounced on
//   both press and release, and produces exactly one pulse per press. A single
//   arbiter serializes the pulses so that at most one output is high at a time,
//   with at least one idle cycle between consecutive pulses. A CLEAR pulse is
//   issued automatically when reset is released.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronized level must hold to be accepted
//   PULSE_CYCLES     width of the RUN/HALT/STEPM/STEPI pulses
//   CLEAR_CYCLES     width of the CLEAR pulse
//
// Ports:
//   SYSCLK           clock
//   RESET            synchronous, active-high reset
//   SW_RUN, SW_HALT, SW_STEPM, SW_STEPI, SW_CLEAR
//                    raw asynchronous switches, high = pressed
//   RUN, HALT, STEPM, STEPI, CLEAR
//                    registered command pulses
//   BUSY             registered OR of all command pulses
//
// Build option:
//   FRONT_PANEL_AUTORUN_EN  when defined, one RUN pulse follows the power-on
//                           CLEAR (after a one-cycle gap) before any switch
//                           request is served.
// -----------------------------------------------------------------------------
module front_panel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 16,
    parameter int CLEAR_CYCLES    = 64
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic SW_RUN,
    input  logic SW_HALT,
    input  logic SW_STEPM,
    input  logic SW_STEPI,
    input  logic SW_CLEAR,
    output logic RUN,
    output logic HALT,
    output logic STEPM,
    output logic STEPI,
    output logic CLEAR,
    output logic BUSY
);

    localparam int NSW = 5;

    // Switch index doubles as grant priority: lower index wins.
    localparam int IX_CLEAR = 0;
    localparam int IX_HALT  = 1;
    localparam int IX_RUN   = 2;
    localparam int IX_STEPI = 3;
    localparam int IX_STEPM = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRESS_DB = 3'd1;
    localparam logic [2:0] S_PENDING  = 3'd2;
    localparam logic [2:0] S_WAIT_REL = 3'd3;
    localparam logic [2:0] S_REL_DB   = 3'd4;

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int              DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

    localparam int              PMAX      = (CLEAR_CYCLES > PULSE_CYCLES) ? CLEAR_CYCLES : PULSE_CYCLES;
    localparam int              PC_W      = $clog2(PMAX + 1);
    localparam logic [PC_W-1:0] PULSE_LEN = PC_W'(PULSE_CYCLES);
    localparam logic [PC_W-1:0] CLEAR_LEN = PC_W'(CLEAR_CYCLES);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [PC_W-1:0] PC_ZERO   = PC_W'(0);

`ifdef FRONT_PANEL_AUTORUN_EN
    localparam logic AUTORUN_AT_RESET = 1'b1;
`else
    localparam logic AUTORUN_AT_RESET = 1'b0;
`endif

    logic [NSW-1:0]  sw_raw_s;
    logic [NSW-1:0]  sync1_q;
    logic [NSW-1:0]  sync2_q;
    logic [NSW-1:0]  req_s;
    logic [NSW-1:0]  grant_s;
    logic [NSW-1:0]  out_q;
    logic [NSW-1:0]  out_d;
    logic [2:0]      st_q  [NSW];
    logic [2:0]      st_d  [NSW];
    logic [DB_W-1:0] dbc_q [NSW];
    logic [DB_W-1:0] dbc_d [NSW];
    logic [PC_W-1:0] pcnt_q;
    logic [PC_W-1:0] pcnt_d;
    logic [PC_W-1:0] len_s;
    logic            busy_q;
    logic            por_q;
    logic            por_d;
    logic            autorun_q;
    logic            autorun_d;
    logic            arb_open_s;

    assign sw_raw_s = {SW_STEPM, SW_STEPI, SW_RUN, SW_HALT, SW_CLEAR};

    // Two-flop synchronizers, one per switch.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            sync1_q <= {NSW{1'b0}};
            sync2_q <= {NSW{1'b0}};
        end else begin
            sync1_q <= sw_raw_s;
            sync2_q <= sync1_q;
        end
    end

    // A switch requests service while its FSM sits in PENDING.
    always_comb begin
        req_s = {NSW{1'b0}};
        for (int i = 0; i < NSW; i++) begin
            req_s[i] = (st_q[i] == S_PENDING);
        end
    end

    // Power-on CLEAR and autorun own the pulse engine before any switch.
    assign arb_open_s = ~busy_q & ~por_q & ~autorun_q;

    // Fixed-priority arbiter: CLEAR > HALT > RUN > STEPI > STEPM.
    always_comb begin
        grant_s = 5'b00000;
        if (arb_open_s) begin
            casez (req_s)
                5'b????1: grant_s = 5'b00001;
                5'b???10: grant_s = 5'b00010;
                5'b??100: grant_s = 5'b00100;
                5'b?1000: grant_s = 5'b01000;
                5'b10000: grant_s = 5'b10000;
                default:  grant_s = 5'b00000;
            endcase
        end else begin
            grant_s = 5'b00000;
        end
    end

    // Per-switch press/release debounce FSMs.
    // PRESS_DB and REL_DB each last DEBOUNCE_CYCLES cycles of a steady level;
    // the counter stops at DB_LAST because reaching it always leaves the state.
    always_comb begin
        for (int i = 0; i < NSW; i++) begin
            st_d[i]  = st_q[i];
            dbc_d[i] = dbc_q[i];
            case (st_q[i])
                S_IDLE: begin
                    dbc_d[i] = DB_ZERO;
                    if (sync2_q[i]) begin
                        st_d[i] = S_PRESS_DB;
                    end else begin
                        st_d[i] = S_IDLE;
                    end
                end
                S_PRESS_DB: begin
                    if (!sync2_q[i]) begin
                        st_d[i]  = S_IDLE;
                        dbc_d[i] = DB_ZERO;
                    end else if (dbc_q[i] == DB_LAST) begin
                        st_d[i]  = S_PENDING;
                        dbc_d[i] = DB_ZERO;
                    end else begin
                        dbc_d[i] = dbc_q[i] + DB_ONE;
                    end
                end
                S_PENDING: begin
                    if (grant_s[i]) begin
                        st_d[i] = S_WAIT_REL;
                    end else begin
                        st_d[i] = S_PENDING;
                    end
                end
                S_WAIT_REL: begin
                    dbc_d[i] = DB_ZERO;
                    if (!sync2_q[i]) begin
                        st_d[i] = S_REL_DB;
                    end else begin
                        st_d[i] = S_WAIT_REL;
                    end
                end
                S_REL_DB: begin
                    if (sync2_q[i]) begin
                        st_d[i]  = S_WAIT_REL;
                        dbc_d[i] = DB_ZERO;
                    end else if (dbc_q[i] == DB_LAST) begin
                        st_d[i]  = S_IDLE;
                        dbc_d[i] = DB_ZERO;
                    end else begin
                        dbc_d[i] = dbc_q[i] + DB_ONE;
                    end
                end
                default: begin
                    st_d[i]  = S_IDLE;
                    dbc_d[i] = DB_ZERO;
                end
            endcase
        end
    end

    // Debounce FSM state and counter registers.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            for (int i = 0; i < NSW; i++) begin
                st_q[i]  <= S_IDLE;
                dbc_q[i] <= DB_ZERO;
            end
        end else begin
            for (int i = 0; i < NSW; i++) begin
                st_q[i]  <= st_d[i];
                dbc_q[i] <= dbc_d[i];
            end
        end
    end

    assign len_s = out_q[IX_CLEAR] ? CLEAR_LEN : PULSE_LEN;

    // Pulse engine: power-on CLEAR, then optional autorun, then granted switches.
    // pcnt_q holds the number of cycles the current pulse has already been high,
    // so the pulse drops on the edge where it equals the pulse length.
    always_comb begin
        out_d     = out_q;
        pcnt_d    = pcnt_q;
        por_d     = por_q;
        autorun_d = autorun_q;
        if (por_q) begin
            out_d  = 5'b00001;
            pcnt_d = PC_ONE;
            por_d  = 1'b0;
        end else if (busy_q) begin
            if (pcnt_q >= len_s) begin
                out_d  = 5'b00000;
                pcnt_d = PC_ZERO;
            end else begin
                pcnt_d = pcnt_q + PC_ONE;
            end
        end else if (autorun_q) begin
            out_d     = 5'b00100;
            pcnt_d    = PC_ONE;
            autorun_d = 1'b0;
        end else if (grant_s != 5'b00000) begin
            out_d  = grant_s;
            pcnt_d = PC_ONE;
        end else begin
            out_d  = out_q;
            pcnt_d = pcnt_q;
        end
    end

    // Pulse engine registers; BUSY is registered alongside the outputs it mirrors.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            out_q     <= 5'b00000;
            pcnt_q    <= PC_ZERO;
            busy_q    <= 1'b0;
            por_q     <= 1'b1;
            autorun_q <= AUTORUN_AT_RESET;
        end else begin
            out_q     <= out_d;
            pcnt_q    <= pcnt_d;
            busy_q    <= |out_d;
            por_q     <= por_d;
            autorun_q <= autorun_d;
        end
    end

    assign CLEAR = out_q[IX_CLEAR];
    assign HALT  = out_q[IX_HALT];
    assign RUN   = out_q[IX_RUN];
    assign STEPI = out_q[IX_STEPI];
    assign STEPM = out_q[IX_STEPM];
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_front_panel.sv
// -----------------------------------------------------------------------------
// tb_front_panel
//
// Drives front_panel with DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, CLEAR_CYCLES=6.
// A run-length reference model predicts every output each cycle; a table of
// single presses and hand-written multi-cycle sequences check the timing rules
// directly, followed by randomized switch activity with occasional resets.
// Bit order of all 5/6-bit vectors: 0 CLEAR, 1 HALT, 2 RUN, 3 STEPI, 4 STEPM,
// 5 BUSY.
// -----------------------------------------------------------------------------
module tb_front_panel;

    localparam int D = 8;
    localparam int P = 4;
    localparam int C = 6;
    localparam int LAT = 2 + D + 1;

    localparam int PH_ARMED = 0;
    localparam int PH_PEND  = 1;
    localparam int PH_HELD  = 2;

`ifdef FRONT_PANEL_AUTORUN_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] raw;
    logic       run_o, halt_o, stepm_o, stepi_o, clear_o, busy_o;

    front_panel #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES   (P),
        .CLEAR_CYCLES   (C)
    ) dut (
        .SYSCLK  (clk),
        .RESET   (rst),
        .SW_RUN  (raw[2]),
        .SW_HALT (raw[1]),
        .SW_STEPM(raw[4]),
        .SW_STEPI(raw[3]),
        .SW_CLEAR(raw[0]),
        .RUN     (run_o),
        .HALT    (halt_o),
        .STEPM   (stepm_o),
        .STEPI   (stepi_o),
        .CLEAR   (clear_o),
        .BUSY    (busy_o)
    );

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int mon_fails = 0;

    logic [5:0] obs;
    logic [5:0] expv;
    logic [5:0] trace [256];

    // Reference model: switch phases with run lengths of synchronized samples.
    int         m_phase [5];
    int         m_hr    [5];
    int         m_lr    [5];
    logic [4:0] m_d1, m_d2;
    bit         m_por, m_ar;
    int         m_rem, m_cur;

    typedef struct {
        int sw;
        int hold;
        int pulses;
        int rise;
        int width;
    } vec_t;

    vec_t vecs [6];
    int   pu, ri, wi, ot, n, rst_hold;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [4:0] s;
        int g;
        if (rst) begin
            m_d1  = 5'b00000;
            m_d2  = 5'b00000;
            m_por = 1'b1;
            m_ar  = AR;
            m_rem = 0;
            m_cur = 0;
            for (int i = 0; i < 5; i++) begin
                m_phase[i] = PH_ARMED;
                m_hr[i]    = 0;
                m_lr[i]    = 0;
            end
        end else begin
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = raw;
            g    = -1;
            if (m_por) begin
                m_por = 1'b0;
                m_cur = 0;
                m_rem = C;
            end else if (m_rem > 0) begin
                m_rem--;
            end else if (m_ar) begin
                m_ar  = 1'b0;
                m_cur = 2;
                m_rem = P;
            end else begin
                // Lowest index is highest priority.
                for (int i = 4; i >= 0; i--) begin
                    if (m_phase[i] == PH_PEND) g = i;
                end
                if (g >= 0) begin
                    m_cur = g;
                    m_rem = (g == 0) ? C : P;
                end
            end
            // A press is accepted on the (D+1)-th consecutive high sample seen
            // while armed; re-arming needs D+1 consecutive low samples after the grant.
            for (int i = 0; i < 5; i++) begin
                if (m_phase[i] == PH_ARMED) begin
                    if (s[i]) begin
                        m_hr[i]++;
                        if (m_hr[i] == D + 1) begin
                            m_phase[i] = PH_PEND;
                            m_hr[i]    = 0;
                        end
                    end else begin
                        m_hr[i] = 0;
                    end
                end else if (m_phase[i] == PH_PEND) begin
                    if (g == i) begin
                        m_phase[i] = PH_HELD;
                        m_lr[i]    = 0;
                    end
                end else begin
                    if (!s[i]) begin
                        m_lr[i]++;
                        if (m_lr[i] == D + 1) begin
                            m_phase[i] = PH_ARMED;
                            m_lr[i]    = 0;
                        end
                    end else begin
                        m_lr[i] = 0;
                    end
                end
            end
        end
    endtask

    // One clock: model step, edge, then compare DUT against model on the falling edge.
    task automatic tick();
        logic [4:0] one;
        one = 5'b00001;
        model_step();
        @(posedge clk);
        @(negedge clk);
        obs  = {busy_o, stepm_o, stepi_o, run_o, halt_o, clear_o};
        expv = (m_rem > 0) ? {1'b1, one << m_cur} : 6'b000000;
        checks++;
        if (obs !== expv) begin
            errors++;
            if (mon_fails < 20)
                $display("FAIL monitor cycle %0d: outputs got %b, expected %b", cyc, obs, expv);
            mon_fails++;
        end
        cyc++;
    endtask

    task automatic idle(input int cnt);
        raw = 5'b00000;
        for (int j = 0; j < cnt; j++) tick();
    endtask

    // Pulse statistics of output k over trace[0..len-1].
    task automatic analyse(input int k, input int len, output int pulses,
                           output int rise, output int width, output int others);
        logic cur_b, prev_b;
        pulses = 0;
        rise   = -1;
        width  = 0;
        others = 0;
        for (int j = 0; j < len; j++) begin
            cur_b  = trace[j][k];
            prev_b = (j > 0) ? trace[j-1][k] : 1'b0;
            if (cur_b && !prev_b) begin
                pulses++;
                if (pulses == 1) rise = j;
            end
            if (cur_b && pulses == 1) width++;
            for (int m = 0; m < 5; m++) begin
                if (m != k && trace[j][m]) others++;
            end
        end
    endtask

    initial begin
        vecs[0] = '{0, 15, 1, LAT, C};
        vecs[1] = '{1, 12, 1, LAT, P};
        vecs[2] = '{2, 30, 1, LAT, P};
        vecs[3] = '{4,  9, 1, LAT, P};
        vecs[4] = '{4,  8, 0, -1,  0};
        vecs[5] = '{3, 50, 1, LAT, P};

        rst = 1'b1;
        raw = 5'b00000;
        for (int j = 0; j < 4; j++) tick();

        // Reset release and power-on CLEAR (trace[0] is the last reset cycle).
        for (int j = 0; j < 40; j++) begin
            rst = (j == 0);
            tick();
            trace[j] = obs;
        end
        chk("reset outputs", int'(trace[0]), 0);
        chk("por busy", int'(trace[1][5]), 1);
        analyse(0, 40, pu, ri, wi, ot);
        chk("por clear pulses", pu, 1);
        chk("por clear rise", ri, 1);
        chk("por clear width", wi, C);
        chk("por other outputs", ot, AR ? P : 0);
        analyse(2, 40, pu, ri, wi, ot);
        chk("autorun pulses", pu, AR ? 1 : 0);
        chk("autorun rise", ri, AR ? C + 2 : -1);

        // Single presses from the table.
        for (int v = 0; v < 6; v++) begin
            n = vecs[v].hold + 30;
            for (int j = 0; j < n; j++) begin
                raw = (j < vecs[v].hold) ? (5'b00001 << vecs[v].sw) : 5'b00000;
                tick();
                trace[j] = obs;
            end
            analyse(vecs[v].sw, n, pu, ri, wi, ot);
            chk($sformatf("vec%0d pulses", v), pu, vecs[v].pulses);
            chk($sformatf("vec%0d rise", v), ri, vecs[v].rise);
            chk($sformatf("vec%0d width", v), wi, vecs[v].width);
            chk($sformatf("vec%0d others", v), ot, 0);
            idle(5);
        end

        // Bounce: high 5, low 2, high 20 on SW_RUN; final rise at index 7.
        for (int j = 0; j < 60; j++) begin
            raw = ((j < 5) || (j >= 7 && j < 27)) ? 5'b00100 : 5'b00000;
            tick();
            trace[j] = obs;
        end
        analyse(2, 60, pu, ri, wi, ot);
        chk("bounce pulses", pu, 1);
        chk("bounce rise", ri, 7 + LAT);
        chk("bounce width", wi, P);
        idle(5);

        // HALT and STEPM together: HALT first, one idle cycle, then STEPM.
        for (int j = 0; j < 50; j++) begin
            raw = (j < 20) ? 5'b10010 : 5'b00000;
            tick();
            trace[j] = obs;
        end
        analyse(1, 50, pu, ri, wi, ot);
        chk("simul halt pulses", pu, 1);
        chk("simul halt rise", ri, LAT);
        chk("simul halt width", wi, P);
        analyse(4, 50, pu, ri, wi, ot);
        chk("simul stepm pulses", pu, 1);
        chk("simul stepm rise", ri, LAT + P + 1);
        chk("simul stepm width", wi, P);
        idle(5);

        // STEPI released and re-pressed after 2 low cycles: one pulse only.
        for (int j = 0; j < 80; j++) begin
            raw = ((j < 20) || (j >= 22 && j < 42)) ? 5'b01000 : 5'b00000;
            tick();
            trace[j] = obs;
        end
        analyse(3, 80, pu, ri, wi, ot);
        chk("repress pulses", pu, 1);
        chk("repress rise", ri, LAT);
        idle(5);

        // Reset during the 2nd RUN cycle with STEPI pending behind it.
        for (int j = 0; j < 70; j++) begin
            raw = (j < 12) ? 5'b01100 : 5'b00000;
            rst = (j >= 13 && j <= 15);
            tick();
            trace[j] = obs;
        end
        rst = 1'b0;
        chk("midreset run before", int'(trace[12][2]), 1);
        chk("midreset run dropped", int'(trace[13][2]), 0);
        chk("midreset busy dropped", int'(trace[13][5]), 0);
        analyse(3, 70, pu, ri, wi, ot);
        chk("midreset stepi discarded", pu, 0);
        analyse(0, 70, pu, ri, wi, ot);
        chk("midreset clear pulses", pu, 1);
        chk("midreset clear rise", ri, 16);
        chk("midreset clear width", wi, C);
        analyse(2, 70, pu, ri, wi, ot);
        chk("midreset run pulses", pu, AR ? 2 : 1);
        idle(5);

        // Randomized switch activity with occasional resets.
        rst_hold = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(11, 0) == 0) raw[i] = ~raw[i];
            end
            if ($urandom_range(999, 0) == 0) rst_hold = 3;
            rst = (rst_hold > 0);
            if (rst_hold > 0) rst_hold--;
            tick();
        end
        rst = 1'b0;
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
